// File: rtl/clk_div_ctrl_if.sv
// Divisor configuration channel between a requester (master) and clk_div_ctrl (slave).
interface clk_div_ctrl_if #(
  parameter int unsigned W = 8
);
  // Handshake: a divisor transfers on each rising clk edge where cfg_valid && cfg_ready.
  // The master holds cfg_valid and cfg_div stable until that edge, and cfg_ready
  // never depends on cfg_valid. cfg_done/cfg_err are one-cycle status pulses.
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         cfg_done;
  logic         cfg_err;

  modport master (output cfg_valid, cfg_div, input cfg_ready, cfg_done, cfg_err);
  modport slave  (input cfg_valid, cfg_div, output cfg_ready, cfg_done, cfg_err);
endinterface

// File: rtl/clk_div_ctrl.sv
// Run-time controller for an even-ratio clock divider: glitch-free divisor
// updates at output-period boundaries plus clean start/stop of clk_out.
module clk_div_ctrl #(
  parameter int unsigned W           = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  clk_div_ctrl_if.slave cfg,
  output logic          clk_out,
  output logic          tick,
  output logic [W-1:0]  cur_div,
  output logic          running,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         phase_q, phase_d;
  logic         tick_q, tick_d;
  logic [W-1:0] cur_div_q, cur_div_d;
  logic         pend_q, pend_d;
  logic [W-1:0] pend_div_q, pend_div_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  logic [W-1:0] half;
  logic [W-1:0] half_m1;
  logic         half_end;
  logic         accept;
  logic         div_ok;

  assign half     = cur_div_q >> 1;
  assign half_m1  = half - W'(1);
  assign half_end = (cnt_q == half_m1);
  assign accept   = cfg.cfg_valid && !pend_q;
  assign div_ok   = !cfg.cfg_div[0] && (cfg.cfg_div >= W'(2));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    cur_div_d  = cur_div_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (accept) begin
      if (div_ok) begin
        pend_d     = 1'b1;
        pend_div_d = cfg.cfg_div;
      end else begin
        err_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: begin
        phase_d = 1'b0;
        cnt_d   = '0;
        // No period in flight: a pending or just-accepted divisor takes effect now,
        // so a start on this same edge already runs at the new rate.
        if (pend_d) begin
          cur_div_d = pend_div_d;
          pend_d    = 1'b0;
          done_d    = 1'b1;
        end
        if (en) begin
          state_d = RUN;
          phase_d = 1'b1;
        end
      end
      RUN, STOPPING: begin
        if (state_q == STOPPING && !phase_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (half_end) begin
          cnt_d   = '0;
          phase_d = !phase_q;
          // High->low toggle is the period boundary; only a divisor accepted
          // before this edge (pend_q) may be applied here.
          if (phase_q) begin
            if (pend_q) begin
              cur_div_d = pend_div_q;
              pend_d    = 1'b0;
              done_d    = 1'b1;
            end
            if (state_q == STOPPING) begin
              state_d = IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q + W'(1);
        end
        if (state_q == RUN && !en) begin
          state_d = STOPPING;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    tick_d = phase_d && !phase_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      tick_q     <= 1'b0;
      cur_div_q  <= W'(DEFAULT_DIV);
      pend_q     <= 1'b0;
      pend_div_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      tick_q     <= tick_d;
      cur_div_q  <= cur_div_d;
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign clk_out       = phase_q;
  assign tick          = tick_q;
  assign cur_div       = cur_div_q;
  assign running       = (state_q != IDLE);
  assign state_dbg     = state_q;
  assign cfg.cfg_ready = !pend_q;
  assign cfg.cfg_done  = done_q;
  assign cfg.cfg_err   = err_q;

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-time controller for the even-number clock frequency divider. It owns the active divisor and accepts new divisors over a valid/ready handshake. It applies each new divisor only at an output-period boundary, so the output never glitches. It also starts and stops the divided clock cleanly and produces a 50% duty-cycle `clk_out` at `clk / div`, plus status pulses for the surrounding logic.

## Interface
- `W`, 8, width of divisor bus and internal half-period counter
- `DEFAULT_DIV`, 2, divisor loaded at reset; must be even and ≥2
- `clk` input 1: single system clock, all logic on rising edge
- `rst` input 1: asynchronous, active-low reset
- `en` input 1: level enable; 1 = run divided clock, 0 = stop cleanly
- `cfg_valid` input 1: new divisor offered
- `cfg_div` input W: requested divisor
- `cfg_ready` output 1: controller can accept a divisor
- `cfg_done` output 1: one-cycle pulse, pending divisor became active
- `cfg_err` output 1: one-cycle pulse, offered divisor rejected
- `clk_out` output 1: divided clock, registered
- `tick` output 1: one-cycle pulse in the cycle `clk_out` goes 0→1
- `cur_div` output W: currently active divisor
- `running` output 1: high in RUN and STOPPING

## Operation
- Reset, asynchronous:
  - state IDLE, `clk_out`=0, `tick`=0, `cfg_done`=0, `cfg_err`=0
  - `cfg_ready`=1, `cur_div`=DEFAULT_DIV, pending cleared, counter=0
- Internal registers:
  - `half` = `cur_div`>>1
  - counter `cnt` counts 0..`half`-1
  - `phase` drives `clk_out`
- Divisor validation on accept (`cfg_valid`&&`cfg_ready`):
  - Invalid means `cfg_div` odd or `cfg_div`<2. `cfg_err` pulses next cycle and nothing is stored.
  - Valid: the divisor is stored as pending and `cfg_ready` drops next cycle. It stays low until the pending divisor is applied.
- States:
  - IDLE: `clk_out`=0. A pending divisor is applied in the cycle after accept. If `en`=1 is sampled, go to RUN with `phase`=1 and `cnt`=0.
  - RUN: `cnt` increments each cycle. At `cnt`==`half`-1 the controller toggles `phase` and clears `cnt`. The high→low toggle is the period boundary, where a pending divisor (accepted in an earlier cycle) is loaded into `cur_div`/`half`. `en`=0 sampled goes to STOPPING.
  - STOPPING: if `phase`=0, go to IDLE next cycle. If `phase`=1, finish the current high half-period; at the high→low toggle go to IDLE and apply any pending divisor there. `en` returning to 1 here is ignored until IDLE is reached.
- `clk_out` high and low halves are always `half` cycles each. No shortened or stretched half-period is permitted.

## Timing
- `en` sampled high in IDLE → `clk_out`=1 and `tick`=1 on the next cycle.
- Output period is `cur_div` clk cycles. With `div`=2, `clk_out` toggles every cycle.
- `cfg_done`, updated `cur_div` and `cfg_ready`=1 all appear in the same cycle as the boundary `clk_out` 1→0.
  - RUN: this is the boundary cycle.
  - IDLE: this is accept+1.
  - From that cycle on, the low half uses the new `half`.
- Simultaneous events:
  - Accept in the same cycle as a boundary: the divisor is applied at the next boundary, not this one.
  - `en` rise in IDLE in the same cycle a pending divisor is applied: RUN starts with the new divisor.
- Back-to-back configs: while `cfg_ready`=0, `cfg_valid` is held off and not consumed. The offering side must hold `cfg_div` stable.
- Reset mid-period: `clk_out` goes to 0 immediately (asynchronous), and any pending divisor is discarded.
- The W-bit counter never wraps, because `half` ≤ 2^(W-1)-1.

## Test plan
- Reset with `en`=1 held, release `rst` → `clk_out` first rises 1 cycle after release, period 2, `cur_div`=2, `cfg_ready`=1.
- Running at 2, offer `cfg_div`=6 mid-high-phase → `cfg_ready` low next cycle; at the next 1→0 boundary `cfg_done` pulses and `cur_div`=6; then 3 low / 3 high cycles, repeating.
- Offer 5, then 0 → `cfg_err` pulses each time, `cur_div` unchanged, `cfg_ready` stays 1.
- Div=8, drop `en` after 2 high cycles → 2 more high cycles, then `clk_out`=0, IDLE, `running`=0; no runt pulse.
- In IDLE offer 4, assert `en` on the next cycle → `cfg_done` at accept+1, then `clk_out` at period 4 from the first rising edge.
- Div=10 running, assert `rst` low mid-high-phase → `clk_out`=0 asynchronously, pending cleared, `cur_div`=DEFAULT_DIV after release.
